// File: rtl/wb_rr_arbiter_pkg.sv
// rtl/wb_rr_arbiter_pkg.sv - shared types and width helpers for the round-robin Wishbone arbiter
package wb_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  // Index width never drops to zero so a single-master build still elaborates.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// rtl/wb_rr_arbiter_if.sv - bundled master-side and slave-side Wishbone signals of the arbiter
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  logic [NUM_MASTERS-1:0]        wbm_cyc_i;
  logic [NUM_MASTERS-1:0]        wbm_stb_i;
  logic [NUM_MASTERS-1:0]        wbm_we_i;
  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i;
  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i;
  logic [NUM_MASTERS*DW/8-1:0]   wbm_sel_i;
  logic [DW-1:0]                 wbm_dat_o;
  logic [NUM_MASTERS-1:0]        wbm_ack_o;
  logic [NUM_MASTERS-1:0]        wbm_err_o;
  logic                          wbs_cyc_o;
  logic                          wbs_stb_o;
  logic                          wbs_we_o;
  logic [AW-1:0]                 wbs_adr_o;
  logic [DW-1:0]                 wbs_dat_o;
  logic [DW/8-1:0]               wbs_sel_o;
  logic [DW-1:0]                 wbs_dat_i;
  logic                          wbs_ack_i;
  logic                          wbs_err_i;

  // slave: the arbiter itself, a slave to the masters; master: the surrounding masters and RAM.
  modport slave (
    input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_sel_i,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o,
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o
  );

  modport master (
    output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_sel_i,
    output wbs_dat_i, wbs_ack_i, wbs_err_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o,
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o
  );
endinterface

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - combinational round-robin picker: first requester above last_owner, wrapping
module wb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid
);
  int   hi_idx;
  int   lo_idx;
  logic hi_found;

  // Descending scan leaves the lowest requester overall and the lowest one above last_owner.
  always_comb begin
    hi_idx   = 0;
    lo_idx   = 0;
    hi_found = 1'b0;
    valid    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = i;
        valid  = 1'b1;
        if (i > int'(last_owner)) begin
          hi_idx   = i;
          hi_found = 1'b1;
        end
      end
    end
    index = hi_found ? IW'(hi_idx) : IW'(lo_idx);
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = valid && (int'(index) == i);
    end
  end
endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone B4 classic arbiter with CYC-envelope ownership
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wb_rr_arbiter_if.slave         bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);
  localparam int IW = idx_width(NUM_MASTERS);
  localparam int CW = cnt_width(TIMEOUT);
  localparam int SW = DW / 8;

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic [CW-1:0]          wd_q, wd_d;

  logic [NUM_MASTERS-1:0] pick_grant;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;

  logic                   own_cyc, own_stb, own_we;
  logic [AW-1:0]          own_adr;
  logic [DW-1:0]          own_dat;
  logic [SW-1:0]          own_sel;
  logic                   raw_stb, wd_fire, slv_err;

  wb_rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req        (bus.wbm_cyc_i),
    .last_owner (last_q),
    .grant      (pick_grant),
    .index      (pick_idx),
    .valid      (pick_valid)
  );

  // grant_q is all-zero outside OWNED, so this mux yields zeros on the slave side when idle.
  always_comb begin
    own_cyc = |(bus.wbm_cyc_i & grant_q);
    own_stb = |(bus.wbm_stb_i & grant_q);
    own_we  = |(bus.wbm_we_i & grant_q);
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      own_adr = own_adr | ({AW{grant_q[i]}} & bus.wbm_adr_i[i*AW +: AW]);
      own_dat = own_dat | ({DW{grant_q[i]}} & bus.wbm_dat_i[i*DW +: DW]);
      own_sel = own_sel | ({SW{grant_q[i]}} & bus.wbm_sel_i[i*SW +: SW]);
    end
  end

  assign raw_stb = own_cyc & own_stb;
  assign wd_fire = (TIMEOUT != 0) && raw_stb && (wd_q == CW'(TIMEOUT));
  assign slv_err = bus.wbs_err_i | wd_fire;

  assign bus.wbs_cyc_o = own_cyc;
  assign bus.wbs_stb_o = raw_stb & ~wd_fire;
  assign bus.wbs_we_o  = own_we;
  assign bus.wbs_adr_o = own_adr;
  assign bus.wbs_dat_o = own_dat;
  assign bus.wbs_sel_o = own_sel;

  // Err dominates a simultaneous ack, and a watchdog pulse masks any late slave ack.
  assign bus.wbm_ack_o = grant_q & {NUM_MASTERS{bus.wbs_ack_i & ~slv_err}};
  assign bus.wbm_err_o = grant_q & {NUM_MASTERS{slv_err}};
  assign bus.wbm_dat_o = (state_q == ST_OWNED) ? bus.wbs_dat_i : '0;
  assign grant_o       = grant_q;
  assign timeout_o     = wd_fire;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWNED;
          grant_d = pick_grant;
          last_d  = pick_idx;
        end
      end
      ST_OWNED: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    if ((TIMEOUT != 0) && raw_stb && !bus.wbs_ack_i && !bus.wbs_err_i && !wd_fire) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // last_owner starts at the top index so master 0 wins the first arbitration.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - self-checking bench for wb_rr_arbiter with a cycle-level ownership model
module tb_wb_rr_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  grant;
  logic          tmo;
  int            checks = 0;
  int            failures = 0;
  int            s_mode = 0;
  logic [31:0]   mem [16];

  wb_rr_arbiter_if #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) bus ();

  wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .grant_o   (grant),
    .timeout_o (tmo)
  );

  always #5 clk = ~clk;

  // Slave: mode 0 zero-wait ack, mode 1 never answers, mode 2 ack and err together.
  assign bus.wbs_ack_i = (s_mode != 1) && bus.wbs_stb_o;
  assign bus.wbs_err_i = (s_mode == 2) && bus.wbs_stb_o;
  assign bus.wbs_dat_i = mem[bus.wbs_adr_o[5:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (bus.wbs_stb_o && bus.wbs_ack_i && !bus.wbs_err_i && bus.wbs_we_o) begin
      mem[bus.wbs_adr_o[5:2]] <= bus.wbs_dat_o;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Model: owner index (-1 idle), last owner, stalled-strobe cycle count.
  int owner = -1, last = N - 1, waitc = 0;
  int owner_n = -1, last_n = N - 1, waitc_n = 0;
  logic [N-1:0]  e_grant, e_ack, e_err;
  logic          e_cyc, e_stb, e_we, e_to, raw, fire, found;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_wdat, e_rdat;
  logic [3:0]    e_sel;

  always @(negedge clk) begin
    e_grant = '0; e_ack = '0; e_err = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_to = 1'b0;
    e_adr = '0; e_wdat = '0; e_rdat = '0; e_sel = '0;
    raw = 1'b0; fire = 1'b0; found = 1'b0;
    owner_n = owner; last_n = last; waitc_n = 0;
    if (!rst) begin
      if (owner >= 0) begin
        e_grant = N'(1 << owner);
        e_cyc   = logic'(bus.wbm_cyc_i >> owner);
        raw     = e_cyc && logic'(bus.wbm_stb_i >> owner);
        fire    = (TO > 0) && raw && (waitc == TO);
        e_stb   = raw && !fire;
        e_we    = logic'(bus.wbm_we_i >> owner);
        e_adr   = AW'(bus.wbm_adr_i >> (owner * AW));
        e_wdat  = DW'(bus.wbm_dat_i >> (owner * DW));
        e_sel   = 4'(bus.wbm_sel_i >> (owner * 4));
        e_rdat  = bus.wbs_dat_i;
        e_to    = fire;
        if (bus.wbs_err_i || fire) e_err = e_grant;
        else if (bus.wbs_ack_i) e_ack = e_grant;
        if (raw && !fire && !bus.wbs_ack_i && !bus.wbs_err_i) waitc_n = waitc + 1;
        if (!e_cyc) owner_n = -1;
      end else begin
        for (int off = 1; off <= N; off++) begin
          int c;
          c = (last + off) % N;
          if (!found && logic'(bus.wbm_cyc_i >> c)) begin
            found = 1'b1;
            owner_n = c;
            last_n = c;
          end
        end
      end
    end
    chk("grant", 64'(grant), 64'(e_grant));
    chk("wbs_cyc", 64'(bus.wbs_cyc_o), 64'(e_cyc));
    chk("wbs_stb", 64'(bus.wbs_stb_o), 64'(e_stb));
    chk("wbs_we", 64'(bus.wbs_we_o), 64'(e_we));
    chk("wbs_adr", 64'(bus.wbs_adr_o), 64'(e_adr));
    chk("wbs_dat", 64'(bus.wbs_dat_o), 64'(e_wdat));
    chk("wbs_sel", 64'(bus.wbs_sel_o), 64'(e_sel));
    chk("wbm_ack", 64'(bus.wbm_ack_o), 64'(e_ack));
    chk("wbm_err", 64'(bus.wbm_err_o), 64'(e_err));
    chk("wbm_dat", 64'(bus.wbm_dat_o), 64'(e_rdat));
    chk("timeout", 64'(tmo), 64'(e_to));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= -1;
      last  <= N - 1;
      waitc <= 0;
    end else begin
      owner <= owner_n;
      last  <= last_n;
      waitc <= waitc_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_m(input int m, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    logic [N-1:0] b;
    b = N'(1 << m);
    bus.wbm_cyc_i = c ? (bus.wbm_cyc_i | b) : (bus.wbm_cyc_i & ~b);
    bus.wbm_stb_i = s ? (bus.wbm_stb_i | b) : (bus.wbm_stb_i & ~b);
    bus.wbm_we_i  = w ? (bus.wbm_we_i | b) : (bus.wbm_we_i & ~b);
    bus.wbm_adr_i[m*AW +: AW] = a;
    bus.wbm_dat_i[m*DW +: DW] = d;
    bus.wbm_sel_i[m*4 +: 4]   = 4'hF;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1);
  end

  initial begin
    bus.wbm_cyc_i = '0; bus.wbm_stb_i = '0; bus.wbm_we_i = '0;
    bus.wbm_adr_i = '0; bus.wbm_dat_i = '0; bus.wbm_sel_i = '0;

    // Single master write, zero-wait ack.
    do_reset();
    set_m(0, 1, 1, 1, 32'h10, 32'hDEADBEEF);
    at_neg(); chk("t1_c0_grant", 64'(grant), 64'h0); chk("t1_c0_cyc", 64'(bus.wbs_cyc_o), 64'h0);
    tick(); at_neg();
    chk("t1_c1_grant", 64'(grant), 64'h1); chk("t1_c1_cyc", 64'(bus.wbs_cyc_o), 64'h1);
    chk("t1_c1_ack", 64'(bus.wbm_ack_o), 64'h1);
    tick(); set_m(0, 0, 0, 0, 32'h0, 32'h0); at_neg();
    chk("t1_k_cyc", 64'(bus.wbs_cyc_o), 64'h0); chk("t1_k_grant", 64'(grant), 64'h1);
    tick(); at_neg(); chk("t1_k1_grant", 64'(grant), 64'h0);
    chk("t1_mem", 64'(mem[4]), 64'hDEADBEEF);

    // Both request after reset: master 0 first, then master 1, then alternation.
    do_reset();
    set_m(0, 1, 1, 0, 32'h20, 32'h0); set_m(1, 1, 1, 0, 32'h24, 32'h0);
    tick(); at_neg(); chk("t2_first_grant", 64'(grant), 64'h1); chk("t2_first_ack", 64'(bus.wbm_ack_o), 64'h1);
    tick(); set_m(0, 0, 0, 0, 32'h0, 32'h0); at_neg(); chk("t2_k_grant", 64'(grant), 64'h1);
    tick(); at_neg(); chk("t2_k1_grant", 64'(grant), 64'h0);
    tick(); at_neg(); chk("t2_k2_grant", 64'(grant), 64'h2); chk("t2_k2_ack", 64'(bus.wbm_ack_o), 64'h2);
    tick(); set_m(1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    tick(); set_m(0, 1, 1, 0, 32'h20, 32'h0); set_m(1, 1, 1, 0, 32'h24, 32'h0);
    at_neg(); chk("t2_re_idle", 64'(grant), 64'h0);
    tick(); at_neg(); chk("t2_re_grant", 64'(grant), 64'h1);

    // Master 1 holds four back-to-back reads while master 0 waits.
    tick(); set_m(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    tick(); set_m(0, 1, 1, 0, 32'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_m(1, 1, 1, 0, 32'h24 + 32'(4 * i), 32'h0);
      at_neg();
      chk("t3_grant", 64'(grant), 64'h2);
      chk("t3_ack", 64'(bus.wbm_ack_o), 64'h2);
      chk("t3_rdata", 64'(bus.wbm_dat_o), 64'hA000_0009 + 64'(i));
      tick();
    end
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    tick(); at_neg(); chk("t3_blocked_idle", 64'(grant), 64'h0);
    tick(); at_neg(); chk("t3_m0_grant", 64'(grant), 64'h1); chk("t3_m0_ack", 64'(bus.wbm_ack_o), 64'h1);
    tick(); set_m(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    tick();

    // Watchdog: slave never answers.
    s_mode = 1;
    set_m(0, 1, 1, 0, 32'h30, 32'h0);
    for (int i = 1; i <= 10; i++) begin
      tick(); at_neg();
      chk("t4_err", 64'(bus.wbm_err_o), (i == 9) ? 64'h1 : 64'h0);
      chk("t4_timeout", 64'(tmo), (i == 9) ? 64'h1 : 64'h0);
      chk("t4_stb", 64'(bus.wbs_stb_o), (i == 9) ? 64'h0 : 64'h1);
    end
    tick(); set_m(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    tick();

    // Simultaneous ack and err.
    s_mode = 2;
    set_m(1, 1, 1, 1, 32'h34, 32'h55);
    tick(); at_neg();
    chk("t5_err", 64'(bus.wbm_err_o), 64'h2); chk("t5_ack", 64'(bus.wbm_ack_o), 64'h0);
    tick(); set_m(1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    tick();

    // Asynchronous reset mid-transfer restores master 0 priority.
    s_mode = 1;
    set_m(0, 1, 1, 0, 32'h38, 32'h0);
    tick(); tick();
    at_neg(); chk("t6_pre_grant", 64'(grant), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_grant", 64'(grant), 64'h0); chk("t6_rst_cyc", 64'(bus.wbs_cyc_o), 64'h0);
    chk("t6_rst_stb", 64'(bus.wbs_stb_o), 64'h0); chk("t6_rst_adr", 64'(bus.wbs_adr_o), 64'h0);
    chk("t6_rst_dat", 64'(bus.wbm_dat_o), 64'h0);
    set_m(1, 1, 1, 0, 32'h3C, 32'h0);
    tick(); tick();
    rst = 1'b0;
    at_neg(); chk("t6_rel_idle", 64'(grant), 64'h0);
    tick(); at_neg(); chk("t6_rel_grant", 64'(grant), 64'h1);
    tick(); set_m(0, 0, 0, 0, 32'h0, 32'h0); set_m(1, 0, 0, 0, 32'h0, 32'h0);
    s_mode = 0;
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
